// File: rtl/xor_arb_if.sv
// ============================================================================
// Module   : xor_arb_if
// Purpose  : Request/response bundle for the shared XOR arbiter.
//            The rsp_parity signal exists only when XOR_ARB_PARITY_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface xor_arb_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_y;
    logic [1:0]            rsp_id;
`ifdef XOR_ARB_PARITY_EN
    logic                  rsp_parity;
`endif

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_y, rsp_id
`ifdef XOR_ARB_PARITY_EN
        , output rsp_parity
`endif
    );

    // Client / test side
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_y, rsp_id
`ifdef XOR_ARB_PARITY_EN
        , input rsp_parity
`endif
    );
endinterface

`default_nettype wire

// File: rtl/xor_arb.sv
// ============================================================================
// Module   : xor_arb
// Purpose  : Round-robin arbiter sharing one registered WIDTH-bit XOR unit
//            among NREQ requesters. Optional parity output: XOR_ARB_PARITY_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module xor_arb #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    xor_arb_if.slave  xif
);
    localparam int IDW = 2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t           state_q;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] y_q;
`ifdef XOR_ARB_PARITY_EN
    logic             parity_q;
`endif

    logic             w_can_accept;
    logic             w_found;
    logic             w_grant;
    logic [IDW-1:0]   w_cand;
    logic [IDW-1:0]   w_gnt_idx;
    logic [NREQ-1:0]  w_gnt_oh;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_y_d;

    assign w_can_accept = (state_q == S_IDLE) || xif.rsp_ready;

    // Search upward from last+1; the IDW-bit add wraps modulo NREQ.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = last_q;
        w_cand    = last_q;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = last_q + IDW'(k);
            if (!w_found && xif.req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // rst_n gating keeps req_ready low for the whole reset interval.
    assign w_grant  = w_can_accept && w_found && rst_n;
    assign w_gnt_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;

    assign xif.req_ready = w_grant ? w_gnt_oh : '0;

    assign w_a   = xif.req_a[int'(w_gnt_idx)*WIDTH +: WIDTH];
    assign w_b   = xif.req_b[int'(w_gnt_idx)*WIDTH +: WIDTH];
    assign w_y_d = w_a ^ w_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= IDW'(NREQ - 1);
            id_q     <= '0;
            y_q      <= '0;
`ifdef XOR_ARB_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else if (w_grant) begin
            state_q  <= S_RESP;
            last_q   <= w_gnt_idx;
            id_q     <= w_gnt_idx;
            y_q      <= w_y_d;
`ifdef XOR_ARB_PARITY_EN
            parity_q <= ^w_y_d;
`endif
        end else if (state_q == S_RESP && xif.rsp_ready) begin
            state_q  <= S_IDLE;
        end
    end

    assign xif.rsp_valid  = (state_q == S_RESP);
    assign xif.rsp_y      = y_q;
    assign xif.rsp_id     = id_q;
`ifdef XOR_ARB_PARITY_EN
    assign xif.rsp_parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_xor_arb.sv
// ============================================================================
// Module   : tb_xor_arb
// Purpose  : Directed self-checking bench for xor_arb (WIDTH=8 and WIDTH=2).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xor_arb;
    logic clk;
    logic rst_n;

    int n_total;
    int n_bad;

    xor_arb_if #(.WIDTH(8), .NREQ(4)) bus  ();
    xor_arb_if #(.WIDTH(2), .NREQ(4)) bus2 ();

    xor_arb #(.WIDTH(8), .NREQ(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .xif   (bus)
    );

    xor_arb #(.WIDTH(2), .NREQ(4)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .xif   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] ey [4];
    int         rr [6];
    logic [3:0] exp_oh;
    logic [1:0] t2;

    initial begin
        ey = '{8'h11, 8'hDD, 8'hC3, 8'h4B};
        rr = '{0, 1, 2, 3, 0, 1};

        rst_n          = 1'b0;
        bus.req_valid  = 4'b1111;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b1;
        bus2.req_valid = 4'b0000;
        bus2.req_a     = '0;
        bus2.req_b     = '0;
        bus2.rsp_ready = 1'b1;
        n_total        = 0;
        n_bad          = 0;

        // Reset state
        #2;
        chk("rst_ready", bus.req_ready, 4'b0000);
        chk("rst_valid", bus.rsp_valid, 1'b0);
        chk("rst_y", bus.rsp_y, 8'h00);
        chk("rst_id", bus.rsp_id, 2'd0);
`ifdef XOR_ARB_PARITY_EN
        chk("rst_par", bus.rsp_parity, 1'b0);
`endif
        tick();
        chk("rst_ready_edge", bus.req_ready, 4'b0000);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2
        bus.req_a = {8'h00, 8'hA5, 8'h00, 8'h00};
        bus.req_b = {8'h00, 8'h0F, 8'h00, 8'h00};
        bus.req_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = 4'b0000;
        chk("single_valid", bus.rsp_valid, 1'b1);
        chk("single_y", bus.rsp_y, 8'hAA);
        chk("single_id", bus.rsp_id, 2'd2);
`ifdef XOR_ARB_PARITY_EN
        chk("single_par", bus.rsp_parity, 1'b0);
`endif
        tick();
        chk("single_drain", bus.rsp_valid, 1'b0);

        // Grant requester 3 alone so the pointer sits at 3
        bus.req_a = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_b = {8'h0F, 8'hF0, 8'hFF, 8'h00};
        bus.req_valid = 4'b1000;
        tick();
        chk("prime_id", bus.rsp_id, 2'd3);
        chk("prime_y", bus.rsp_y, 8'h4B);

        // Round-robin with all requesters continuously valid
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_oh = 4'b0001 << rr[i];
            chk("rr_ready", bus.req_ready, exp_oh);
            tick();
            chk("rr_valid", bus.rsp_valid, 1'b1);
            chk("rr_id", bus.rsp_id, rr[i]);
            chk("rr_y", bus.rsp_y, ey[rr[i]]);
        end

        // Backpressure with requester 1's result held
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", bus.req_ready, 4'b0000);
            tick();
            chk("bp_valid", bus.rsp_valid, 1'b1);
            chk("bp_id", bus.rsp_id, 2'd1);
            chk("bp_y", bus.rsp_y, 8'hDD);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus.req_ready, 4'b0100);
        tick();
        chk("bp_release_valid", bus.rsp_valid, 1'b1);
        chk("bp_release_id", bus.rsp_id, 2'd2);
        chk("bp_release_y", bus.rsp_y, 8'hC3);

        // Wrap-around: after granting 3, requesters 1 and 3 compete
        bus.req_valid = 4'b1000;
        @(negedge clk);
        chk("wrap_ready3", bus.req_ready, 4'b1000);
        tick();
        chk("wrap_id3", bus.rsp_id, 2'd3);
        bus.req_valid = 4'b1010;
        @(negedge clk);
        chk("wrap_ready1", bus.req_ready, 4'b0010);
        tick();
        chk("wrap_id1", bus.rsp_id, 2'd1);
        chk("wrap_y1", bus.rsp_y, 8'hDD);
        @(negedge clk);
        chk("wrap_ready3b", bus.req_ready, 4'b1000);
        tick();
        chk("wrap_id3b", bus.rsp_id, 2'd3);
        chk("wrap_y3b", bus.rsp_y, 8'h4B);
        bus.req_valid = 4'b0000;
        tick();
        chk("wrap_drain", bus.rsp_valid, 1'b0);

        // Reset in the middle of a held result
        bus.req_valid = 4'b0001;
        tick();
        chk("mid_id", bus.rsp_id, 2'd0);
        chk("mid_y", bus.rsp_y, 8'h11);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0011;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_y", bus.rsp_y, 8'h00);
        chk("mid_rst_id", bus.rsp_id, 2'd0);
        chk("mid_rst_ready", bus.req_ready, 4'b0000);
        tick();
        chk("mid_rst_ready_edge", bus.req_ready, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk("post_rst_ready", bus.req_ready, 4'b0001);
        tick();
        chk("post_rst_id", bus.rsp_id, 2'd0);
        chk("post_rst_y", bus.rsp_y, 8'h11);
        bus.req_valid = 4'b0000;

        // Exhaustive 2-bit operands through requester 0
        bus2.req_valid = 4'b0001;
        for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
                bus2.req_a[1:0] = 2'(a);
                bus2.req_b[1:0] = 2'(b);
                tick();
                t2 = 2'(a) ^ 2'(b);
                chk("exh_valid", bus2.rsp_valid, 1'b1);
                chk("exh_y", bus2.rsp_y, t2);
`ifdef XOR_ARB_PARITY_EN
                chk("exh_par", bus2.rsp_parity, t2[0] ^ t2[1]);
`endif
            end
        end
        bus2.req_valid = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/xor_arb.md
# xor_arb

Round-robin arbiter and sequencer that shares one WIDTH-bit bitwise XOR unit among NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The arbiter grants one requester per transaction and computes y = a ^ b in a single registered stage. It returns the result with the winning requester's index over a second valid/ready handshake. It sits between the logic-gate datapath and the client blocks that need XOR service.

## Interface
- WIDTH, 8: operand and result width in bits (≥1).
- NREQ, 4: number of requesters; fixed at 4 in this revision (2-bit id).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester request valid; bit i belongs to requester i.
- req_ready  output  NREQ  per-requester accept; at most one bit set, combinational.
- req_a  input  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b, same packing as req_a.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_y  output  WIDTH  registered a ^ b of the granted request.
- rsp_id  output  2  index of the granted requester.
- rsp_parity  output  1  reduction XOR of rsp_y; present only with XOR_ARB_PARITY_EN.

## Operation
- States: IDLE (no result held) and RESP (result held, rsp_valid=1).
- can_accept = (state==IDLE) | (state==RESP & rsp_ready).
- Grant: when can_accept and any req_valid is set, pick g as the first set bit searching upward from (last+1) mod NREQ with wrap-around. Drive req_ready[g]=1; all other bits are 0.
- req_ready depends only on state, rsp_ready, req_valid and last. It never depends on req_a or req_b.
- On a grant edge:
  - rsp_y <= a[g] ^ b[g].
  - rsp_id <= g.
  - last <= g.
  - state <= RESP.
- RESP with rsp_ready=1 and no grant: state goes to IDLE and rsp_valid drops.
- RESP with rsp_ready=0: rsp_y, rsp_id and rsp_valid are held stable. No grant is made.
- A requester may deassert req_valid before it is granted. No state is kept per request.
- Priority pointer last:
  - Reset value is NREQ-1, so requester 0 wins first.
  - It updates only on a grant.
- Arithmetic: pure bitwise XOR, no carries, width WIDTH in and out.

## Timing
- Reset (asynchronous on rst_n low):
  - state=IDLE
  - rsp_valid=0
  - rsp_y=0
  - rsp_id=0
  - last=NREQ-1
  - rsp_parity=0
  - req_ready=0 while rst_n is low.
- Latency: from the grant edge to rsp_valid=1 is 1 cycle.
- Throughput: 1 result per cycle when rsp_ready is held high and requests are continuous.
- Simultaneous events: rsp_ready=1 together with a pending request in RESP completes the old result and loads the new one on the same edge. rsp_valid stays 1.
- Reset mid-transaction: the held result is discarded. No req_ready is issued until the first cycle after rst_n rises.
- Fairness: a continuously asserted requester is granted within NREQ grants.

## Configuration
- XOR_ARB_PARITY_EN defined:
  - Adds output rsp_parity = ^rsp_y, registered with rsp_y.
  - Its reset value is 0 and it is held stable while rsp_valid=1 and rsp_ready=0.
- XOR_ARB_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Single request: reset, then requester 2 with a=8'hA5, b=8'h0F, rsp_ready=1. Required: req_ready=4'b0100 in the request cycle. Next cycle rsp_valid=1, rsp_y=8'hAA, rsp_id=2, and rsp_parity=0 if enabled.
- Round-robin: all four requesters valid continuously, rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0,1, with one result per cycle.
- Backpressure: rsp_ready=0 for 5 cycles with a result held. Required: rsp_y and rsp_id stable and req_ready=0 throughout. When rsp_ready=1, the next grant loads on that same edge.
- Wrap-around pointer: after a grant to 3, requesters 1 and 3 request together. Required: requester 1 wins first, then 3.
- Reset mid-operation: assert rst_n=0 while in RESP. Required: rsp_valid and rsp_y drop to 0 immediately. After release, requester 0 has priority over requester 1 when both request.
- Exhaustive operands (WIDTH=2): every a,b pair in 0..3 through requester 0. Required: rsp_y = a^b for every pair. With the macro defined, rsp_parity = ^(a^b).
